// File: rtl/result_tx_drain.sv
`default_nettype none
// ============================================================================
// Module   : result_tx_drain
// Purpose  : Drains a host-requested number of words from one selected result
//            FIFO. The words go out as a valid/ready stream, and the final word
//            is marked with tx_last.
// Optional : RESULT_TX_HEADER_EN - adds one header word ahead of the data:
//            {8'hA5, sel[7:0], count[15:0]}.
// Revision : 1.0 - initial release
// ============================================================================
module result_tx_drain #(
    parameter int FIFO_WIDTH         = 32,
    parameter int TOTAL_RESULT_FIFOS = 8,
    parameter int SEL_WIDTH          = 8,
    parameter int COUNT_WIDTH        = 16
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     req_valid,
    output logic                                     req_ready,
    input  logic [SEL_WIDTH-1:0]                     req_sel,
    input  logic [COUNT_WIDTH-1:0]                   req_count,
    input  logic [TOTAL_RESULT_FIFOS*FIFO_WIDTH-1:0] rf_q,
    input  logic [TOTAL_RESULT_FIFOS-1:0]            rf_empty,
    output logic [TOTAL_RESULT_FIFOS-1:0]            rf_rdreq,
    output logic                                     tx_valid,
    input  logic                                     tx_ready,
    output logic [FIFO_WIDTH-1:0]                    tx_data,
    output logic                                     tx_last,
    output logic                                     busy,
    output logic                                     err_sel
);

    localparam logic [1:0] c_st_idle   = 2'd0;
`ifdef RESULT_TX_HEADER_EN
    localparam logic [1:0] c_st_hdr    = 2'd1;
`endif
    localparam logic [1:0] c_st_stream = 2'd2;
    localparam logic [1:0] c_st_flush  = 2'd3;

    logic [1:0]             r_state;
    logic [SEL_WIDTH-1:0]   r_sel;
    logic [COUNT_WIDTH-1:0] r_remaining;
    logic                   r_tx_valid;
    logic [FIFO_WIDTH-1:0]  r_tx_data;
    logic                   r_tx_last;
    logic                   r_busy;
    logic                   r_err_sel;

    logic [FIFO_WIDTH-1:0]  w_head;
    logic                   w_sel_empty;
    logic                   w_out_free;
    logic                   w_pop;
    logic                   w_sel_bad;

    // Select the head word and empty flag of the latched FIFO
    always_comb begin
        w_head      = '0;
        w_sel_empty = 1'b1;
        for (int i = 0; i < TOTAL_RESULT_FIFOS; i++) begin
            if (r_sel == SEL_WIDTH'(i)) begin
                w_head      = rf_q[i*FIFO_WIDTH +: FIFO_WIDTH];
                w_sel_empty = rf_empty[i];
            end
        end
    end

    // The output register can take a new word when it is empty or being consumed
    assign w_out_free = !r_tx_valid || tx_ready;

    // Pop only while streaming, with words owed, data present and room downstream;
    // reset suppresses the pop so FIFO contents survive a mid-transfer reset
    assign w_pop = !reset && (r_state == c_st_stream) && (r_remaining != '0) &&
                   !w_sel_empty && w_out_free;

    assign w_sel_bad = ({1'b0, req_sel} >= (SEL_WIDTH + 1)'(TOTAL_RESULT_FIFOS));

    generate
        for (genvar g = 0; g < TOTAL_RESULT_FIFOS; g++) begin : g_rdreq
            assign rf_rdreq[g] = w_pop && (r_sel == SEL_WIDTH'(g));
        end
    endgenerate

    assign req_ready = (r_state == c_st_idle);
    assign tx_valid  = r_tx_valid;
    assign tx_data   = r_tx_data;
    assign tx_last   = r_tx_last;
    assign busy      = r_busy;
    assign err_sel   = r_err_sel;

    // Request FSM and registered output stage
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_sel       <= '0;
            r_remaining <= '0;
            r_tx_valid  <= 1'b0;
            r_tx_data   <= '0;
            r_tx_last   <= 1'b0;
            r_busy      <= 1'b0;
            r_err_sel   <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (req_valid) begin
                        r_sel       <= req_sel;
                        r_remaining <= req_count;
                        if (w_sel_bad) begin
                            r_err_sel <= 1'b1;
                        end else begin
                            r_busy  <= 1'b1;
`ifdef RESULT_TX_HEADER_EN
                            r_state <= c_st_hdr;
`else
                            r_state <= c_st_stream;
`endif
                        end
                    end
                end
`ifdef RESULT_TX_HEADER_EN
                c_st_hdr: begin
                    if (w_out_free) begin
                        r_tx_data  <= FIFO_WIDTH'({8'hA5, r_sel[7:0], r_remaining[15:0]});
                        r_tx_valid <= 1'b1;
                        r_tx_last  <= (r_remaining == '0);
                        r_state    <= c_st_stream;
                    end
                end
`endif
                c_st_stream: begin
                    if (w_pop) begin
                        r_tx_data   <= w_head;
                        r_tx_valid  <= 1'b1;
                        r_tx_last   <= (r_remaining == COUNT_WIDTH'(1));
                        r_remaining <= r_remaining - COUNT_WIDTH'(1);
                        if (r_remaining == COUNT_WIDTH'(1)) begin
                            r_state <= c_st_flush;
                        end
                    end else begin
                        // Held word consumed (or nothing held): bubble until data returns
                        if (tx_ready) begin
                            r_tx_valid <= 1'b0;
                            r_tx_last  <= 1'b0;
                        end
                        if (r_remaining == '0) begin
                            r_state <= c_st_flush;
                        end
                    end
                end
                c_st_flush: begin
                    if (w_out_free) begin
                        r_tx_valid <= 1'b0;
                        r_tx_last  <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_result_tx_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_tx_drain
// Purpose  : Directed bench for result_tx_drain with a model of the FIFO bank.
// Revision : 1.0 - initial release
// ============================================================================
module tb_result_tx_drain;

    localparam int FW = 32;
    localparam int NF = 8;
    localparam int SW = 8;
    localparam int CW = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [SW-1:0]     req_sel;
    logic [CW-1:0]     req_count;
    logic [NF*FW-1:0]  rf_q = '0;
    logic [NF-1:0]     rf_empty = '1;
    logic [NF-1:0]     rf_rdreq;
    logic              tx_valid;
    logic              tx_ready;
    logic [FW-1:0]     tx_data;
    logic              tx_last;
    logic              busy;
    logic              err_sel;

    int total = 0;
    int bad   = 0;

    // FIFO bank model: linear storage, pushed by the stimulus, popped on rf_rdreq
    logic [31:0] mem [NF][64];
    int wr_ptr  [NF] = '{default: 0};
    int rd_ptr  [NF] = '{default: 0};
    int pop_cnt [NF] = '{default: 0};
    int pop_empty_err = 0;

    // Expected-word scoreboard for the stream collector
    logic [31:0] exp_w [8];
    int   n_exp;
    int   n_acc;
    int   cyc;
    int   rdy_mode;
    logic prev_stall;
    int   p0;

    always #5 clk = ~clk;

    result_tx_drain #(
        .FIFO_WIDTH(FW), .TOTAL_RESULT_FIFOS(NF), .SEL_WIDTH(SW), .COUNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_sel(req_sel), .req_count(req_count),
        .rf_q(rf_q), .rf_empty(rf_empty), .rf_rdreq(rf_rdreq),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_last(tx_last),
        .busy(busy), .err_sel(err_sel)
    );

    // Show-ahead FIFO model; heads update with NBA so the DUT samples old values
    always @(posedge clk) begin
        for (int i = 0; i < NF; i++) begin
            if (rf_rdreq[i]) begin
                if (rf_empty[i]) pop_empty_err++;
                else rd_ptr[i]++;
                pop_cnt[i]++;
            end
        end
        for (int i = 0; i < NF; i++) begin
            rf_empty[i]          <= (rd_ptr[i] == wr_ptr[i]);
            rf_q[i*FW +: FW]     <= mem[i][rd_ptr[i] % 64];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int f, input logic [31:0] d);
        mem[f][wr_ptr[f] % 64] = d;
        wr_ptr[f]++;
    endtask

    task automatic request(input logic [7:0] sel, input logic [15:0] cnt);
        req_valid = 1'b1;
        req_sel   = sel;
        req_count = cnt;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic start_collect(input int n, input int mode);
        n_exp = n; n_acc = 0; cyc = 0; prev_stall = 1'b0; rdy_mode = mode;
    endtask

    // One cycle of the stream checker: drive tx_ready, check the presented word
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (rdy_mode == 1) tx_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        else               tx_ready = 1'b1;
        if (prev_stall) chk("hold_valid", 64'(tx_valid), 64'(1));
        if (tx_valid) begin
            if (n_acc < n_exp) begin
                chk("tx_data", 64'(tx_data), 64'(exp_w[n_acc]));
                chk("tx_last", 64'(tx_last), 64'(n_acc == n_exp - 1));
            end else begin
                chk("extra_word", 64'(tx_valid), 64'(0));
            end
            if (tx_ready) n_acc++;
        end
        prev_stall = tx_valid && !tx_ready;
    endtask

    task automatic collect(input int budget);
        int g;
        g = 0;
        while ((n_acc < n_exp || busy) && g < budget) begin
            tick();
            g++;
        end
        chk("words_out", 64'(n_acc), 64'(n_exp));
        chk("idle_after", 64'(busy), 64'(0));
        tx_ready = 1'b1;
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_sel = '0; req_count = '0; tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx_valid", 64'(tx_valid), 64'(0));
        chk("rst_tx_data", 64'(tx_data), 64'(0));
        chk("rst_tx_last", 64'(tx_last), 64'(0));
        chk("rst_rdreq", 64'(rf_rdreq), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_err_sel", 64'(err_sel), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(1));
        reset = 1'b0;
        @(negedge clk);

        // 1: sel=3 count=4, full throughput
        for (int k = 0; k < 4; k++) push(3, 32'h11 + 32'(k));
        p0 = pop_cnt[3];
        request(8'd3, 16'd4);
        chk("t1_first_valid", 64'(tx_valid), 64'(0));
        chk("t1_first_rdreq", 64'(rf_rdreq), 64'h08);
        chk("t1_busy", 64'(busy), 64'(1));
        chk("t1_req_ready_busy", 64'(req_ready), 64'(0));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t1_valid", 64'(tx_valid), 64'(1));
            chk("t1_data", 64'(tx_data), 64'(32'h11 + 32'(k)));
            chk("t1_last", 64'(tx_last), 64'(k == 3));
            chk("t1_rdreq", 64'(rf_rdreq), (k < 3) ? 64'h08 : 64'h00);
        end
        @(negedge clk);
        chk("t1_busy_done", 64'(busy), 64'(0));
        chk("t1_req_ready_done", 64'(req_ready), 64'(1));
        chk("t1_valid_done", 64'(tx_valid), 64'(0));
        chk("t1_pops", 64'(pop_cnt[3] - p0), 64'(4));

        // 2: same with tx_ready toggling 1,0,0,1
        for (int k = 0; k < 4; k++) begin
            push(3, 32'h21 + 32'(k));
            exp_w[k] = 32'h21 + 32'(k);
        end
        p0 = pop_cnt[3];
        request(8'd3, 16'd4);
        start_collect(4, 1);
        collect(40);
        chk("t2_pops", 64'(pop_cnt[3] - p0), 64'(4));

        // 3: only two words present, two more arrive later
        push(3, 32'h31); push(3, 32'h32);
        for (int k = 0; k < 4; k++) exp_w[k] = 32'h31 + 32'(k);
        p0 = pop_cnt[3];
        request(8'd3, 16'd4);
        start_collect(4, 0);
        repeat (10) tick();
        chk("t3_partial_words", 64'(n_acc), 64'(2));
        chk("t3_partial_pops", 64'(pop_cnt[3] - p0), 64'(2));
        chk("t3_stall_rdreq", 64'(rf_rdreq), 64'(0));
        chk("t3_stall_valid", 64'(tx_valid), 64'(0));
        chk("t3_stall_busy", 64'(busy), 64'(1));
        push(3, 32'h33); push(3, 32'h34);
        collect(20);
        chk("t3_pops", 64'(pop_cnt[3] - p0), 64'(4));

        // 4: out-of-range select, then a normal request
        request(8'd9, 16'd3);
        chk("t4_err_sel", 64'(err_sel), 64'(1));
        chk("t4_no_busy", 64'(busy), 64'(0));
        chk("t4_no_valid", 64'(tx_valid), 64'(0));
        chk("t4_no_rdreq", 64'(rf_rdreq), 64'(0));
        chk("t4_req_ready", 64'(req_ready), 64'(1));
        repeat (3) @(negedge clk);
        chk("t4_err_sticky", 64'(err_sel), 64'(1));
        push(0, 32'h41); push(0, 32'h42);
        exp_w[0] = 32'h41; exp_w[1] = 32'h42;
        request(8'd0, 16'd2);
        start_collect(2, 0);
        collect(20);
        chk("t4_err_still", 64'(err_sel), 64'(1));

`ifndef RESULT_TX_HEADER_EN
        // count==0: no output, back in IDLE two cycles after acceptance
        request(8'd2, 16'd0);
        chk("z_busy1", 64'(busy), 64'(1));
        chk("z_rdreq", 64'(rf_rdreq), 64'(0));
        @(negedge clk);
        chk("z_busy2", 64'(busy), 64'(1));
        chk("z_valid", 64'(tx_valid), 64'(0));
        @(negedge clk);
        chk("z_idle", 64'(busy), 64'(0));
        chk("z_req_ready", 64'(req_ready), 64'(1));
`endif

        // 5: reset during word 2 of an 8-word transfer
        for (int k = 0; k < 8; k++) push(3, 32'h51 + 32'(k));
        p0 = pop_cnt[3];
        request(8'd3, 16'd8);
`ifdef RESULT_TX_HEADER_EN
        @(negedge clk);
`endif
        @(negedge clk);
        @(negedge clk);
        chk("t5_word2", 64'(tx_data), 64'h52);
        reset = 1'b1;
        #1;
        chk("t5_rst_no_pop", 64'(rf_rdreq), 64'(0));
        @(negedge clk);
        chk("t5_valid", 64'(tx_valid), 64'(0));
        chk("t5_data", 64'(tx_data), 64'(0));
        chk("t5_last", 64'(tx_last), 64'(0));
        chk("t5_busy", 64'(busy), 64'(0));
        chk("t5_err_cleared", 64'(err_sel), 64'(0));
        chk("t5_req_ready", 64'(req_ready), 64'(1));
        reset = 1'b0;
        chk("t5_pops", 64'(pop_cnt[3] - p0), 64'(2));
        chk("t5_level", 64'(wr_ptr[3] - rd_ptr[3]), 64'(6));
        @(negedge clk);
        for (int k = 0; k < 6; k++) exp_w[k] = 32'h53 + 32'(k);
        request(8'd3, 16'd6);
`ifdef RESULT_TX_HEADER_EN
        exp_w[0] = 32'hA503_0006;
        for (int k = 0; k < 6; k++) exp_w[k+1] = 32'h53 + 32'(k);
        start_collect(7, 0);
`else
        start_collect(6, 0);
`endif
        collect(30);

`ifdef RESULT_TX_HEADER_EN
        // 6: header word ahead of data
        push(1, 32'h61); push(1, 32'h62);
        exp_w[0] = 32'hA501_0002; exp_w[1] = 32'h61; exp_w[2] = 32'h62;
        request(8'd1, 16'd2);
        start_collect(3, 0);
        collect(20);
        exp_w[0] = 32'hA501_0000;
        request(8'd1, 16'd0);
        start_collect(1, 0);
        collect(20);
        chk("t6_pops", 64'(pop_cnt[1]), 64'(2));
`else
        chk("other_pops1", 64'(pop_cnt[1]), 64'(0));
`endif

        chk("fifo3_total_pops", 64'(pop_cnt[3]), 64'(20));
        chk("fifo0_total_pops", 64'(pop_cnt[0]), 64'(2));
        chk("fifo2_no_pops", 64'(pop_cnt[2] + pop_cnt[4] + pop_cnt[5] + pop_cnt[6] + pop_cnt[7]), 64'(0));
        chk("pop_on_empty", 64'(pop_empty_err), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
